// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register that feeds the execute-stage forwarding mux.
// It registers the decoded operands and precomputes the forwarding selects
// (00 = register file, 01 = EX/MEM, 10 = MEM/WB) one cycle ahead, so the
// execute mux needs no comparators. It also detects hazards that forwarding
// cannot cover, stalls IF/ID and inserts bubbles on a stall or a flush.
//
// Build option:
//   IDEX_FORWARD_EN  defined   -> forwarding selects are live, forw_on = 1,
//                                 stall only on load-use hazards.
//                    undefined -> selects stay 00, forw_on = 0, stall on any
//                                 RAW dependence on the EX or EX/MEM producer.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid, id_op               decode-stage instruction and opcode
//   id_rs1, id_rs2, id_rd         decode-stage register indices
//   id_data1, id_data2, id_sdata  decode-stage operands and store data
//   mem_valid, mem_regwrite,
//   mem_rd                        instruction currently in EX/MEM
//   ex_hold                       downstream busy, freeze this stage
//   flush                         redirect, kill the decode instruction
//   id_stall                      hold PC and IF/ID this cycle
//   forw_on                       enables forwarding in the execute mux
//   ex_*                          registered execute-stage fields
//   forwA, forwB                  registered forwarding selects
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [6:0]        id_op,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_sdata,
    input  logic              mem_valid,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              id_stall,
    output logic              forw_on,
    output logic              ex_valid,
    output logic              ex_regwrite,
    output logic              ex_isload,
    output logic [6:0]        ex_op,
    output logic [REG_AW-1:0] ex_rs1,
    output logic [REG_AW-1:0] ex_rs2,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_sdata,
    output logic [1:0]        forwA,
    output logic [1:0]        forwB
);

    // RV32I major opcodes (constant_def.vh encodings)
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_IMM  = 7'b0010011;
    localparam logic [6:0] OP_I_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S_TYPE = 7'b0100011;
    localparam logic [6:0] OP_B_TYPE = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

`ifdef IDEX_FORWARD_EN
    localparam logic FORWARD_ON = 1'b1;
`else
    localparam logic FORWARD_ON = 1'b0;
`endif

    logic              exValid_q,    exValid_d;
    logic              exRegwrite_q, exRegwrite_d;
    logic              exIsload_q,   exIsload_d;
    logic [6:0]        exOp_q,       exOp_d;
    logic [REG_AW-1:0] exRs1_q,      exRs1_d;
    logic [REG_AW-1:0] exRs2_q,      exRs2_d;
    logic [REG_AW-1:0] exRd_q,       exRd_d;
    logic [DATA_W-1:0] exData1_q,    exData1_d;
    logic [DATA_W-1:0] exData2_q,    exData2_d;
    logic [DATA_W-1:0] exSdata_q,    exSdata_d;
    logic [1:0]        forwA_q,      forwA_d;
    logic [1:0]        forwB_q,      forwB_d;

    logic       useRs1;
    logic       useRs2;
    logic       idRegwrite;
    logic       idIsload;
    logic       exHit1;
    logic       exHit2;
    logic       memHit1;
    logic       memHit2;
    logic       hazard;
    logic       stall;
    logic [1:0] selA;
    logic [1:0] selB;

    // Decode which source operands the ID instruction actually reads and
    // whether it produces a register result.
    always_comb begin
        useRs1     = !((id_op == OP_JAL) || (id_op == OP_LUI) || (id_op == OP_AUIPC));
        useRs2     = (id_op == OP_R_TYPE) || (id_op == OP_S_TYPE) || (id_op == OP_B_TYPE);
        idRegwrite = id_valid && ((id_op == OP_R_TYPE) || (id_op == OP_I_IMM) ||
                                  (id_op == OP_I_LOAD) || (id_op == OP_JAL)   ||
                                  (id_op == OP_JALR)   || (id_op == OP_LUI)   ||
                                  (id_op == OP_AUIPC));
        idIsload   = id_valid && (id_op == OP_I_LOAD);
    end

    // Dependence detection against the two older producers. The instruction
    // now in EX will sit in EX/MEM once the ID instruction reaches EX, and
    // the EX/MEM one will sit in MEM/WB, hence the 01/10 encoding.
    always_comb begin
        exHit1  = useRs1 && (id_rs1 != '0) && exValid_q && exRegwrite_q && (exRd_q == id_rs1);
        exHit2  = useRs2 && (id_rs2 != '0) && exValid_q && exRegwrite_q && (exRd_q == id_rs2);
        memHit1 = useRs1 && (id_rs1 != '0) && mem_valid && mem_regwrite && (mem_rd == id_rs1);
        memHit2 = useRs2 && (id_rs2 != '0) && mem_valid && mem_regwrite && (mem_rd == id_rs2);
`ifdef IDEX_FORWARD_EN
        // Only a load in EX cannot be forwarded in time; everything else is
        // picked up by the mux, with the younger (EX) producer winning.
        hazard = id_valid && exValid_q && exIsload_q && (exRd_q != '0) &&
                 ((useRs1 && (exRd_q == id_rs1)) || (useRs2 && (exRd_q == id_rs2)));
        selA   = exHit1 ? 2'b01 : (memHit1 ? 2'b10 : 2'b00);
        selB   = exHit2 ? 2'b01 : (memHit2 ? 2'b10 : 2'b00);
`else
        // Without forwarding the consumer must wait until the producer has
        // left EX/MEM and the register file holds the result.
        hazard = id_valid && (exHit1 || exHit2 || memHit1 || memHit2);
        selA   = 2'b00;
        selB   = 2'b00;
`endif
    end

    // Next-state selection: a downstream hold freezes everything (a pending
    // flush is retried later), a flush beats a hazard, and both a flush and
    // a hazard replace the stage contents with a bubble.
    always_comb begin
        exValid_d    = exValid_q;
        exRegwrite_d = exRegwrite_q;
        exIsload_d   = exIsload_q;
        exOp_d       = exOp_q;
        exRs1_d      = exRs1_q;
        exRs2_d      = exRs2_q;
        exRd_d       = exRd_q;
        exData1_d    = exData1_q;
        exData2_d    = exData2_q;
        exSdata_d    = exSdata_q;
        forwA_d      = forwA_q;
        forwB_d      = forwB_q;
        stall        = 1'b0;

        if (ex_hold) begin
            stall = 1'b1;
        end else if (flush || hazard) begin
            stall        = !flush;
            exValid_d    = 1'b0;
            exRegwrite_d = 1'b0;
            exIsload_d   = 1'b0;
            exOp_d       = '0;
            exRs1_d      = '0;
            exRs2_d      = '0;
            exRd_d       = '0;
            exData1_d    = '0;
            exData2_d    = '0;
            exSdata_d    = '0;
            forwA_d      = 2'b00;
            forwB_d      = 2'b00;
        end else begin
            exValid_d    = id_valid;
            exRegwrite_d = idRegwrite;
            exIsload_d   = idIsload;
            exOp_d       = id_op;
            exRs1_d      = id_rs1;
            exRs2_d      = id_rs2;
            exRd_d       = id_rd;
            exData1_d    = id_data1;
            exData2_d    = id_data2;
            exSdata_d    = id_sdata;
            forwA_d      = selA;
            forwB_d      = selB;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid_q    <= 1'b0;
            exRegwrite_q <= 1'b0;
            exIsload_q   <= 1'b0;
            exOp_q       <= '0;
            exRs1_q      <= '0;
            exRs2_q      <= '0;
            exRd_q       <= '0;
            exData1_q    <= '0;
            exData2_q    <= '0;
            exSdata_q    <= '0;
            forwA_q      <= 2'b00;
            forwB_q      <= 2'b00;
        end else begin
            exValid_q    <= exValid_d;
            exRegwrite_q <= exRegwrite_d;
            exIsload_q   <= exIsload_d;
            exOp_q       <= exOp_d;
            exRs1_q      <= exRs1_d;
            exRs2_q      <= exRs2_d;
            exRd_q       <= exRd_d;
            exData1_q    <= exData1_d;
            exData2_q    <= exData2_d;
            exSdata_q    <= exSdata_d;
            forwA_q      <= forwA_d;
            forwB_q      <= forwB_d;
        end
    end

    assign id_stall    = stall;
    assign forw_on     = FORWARD_ON;
    assign ex_valid    = exValid_q;
    assign ex_regwrite = exRegwrite_q;
    assign ex_isload   = exIsload_q;
    assign ex_op       = exOp_q;
    assign ex_rs1      = exRs1_q;
    assign ex_rs2      = exRs2_q;
    assign ex_rd       = exRd_q;
    assign ex_data1    = exData1_q;
    assign ex_data2    = exData2_q;
    assign ex_sdata    = exSdata_q;
    assign forwA       = forwA_q;
    assign forwB       = forwB_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Self-checking bench for id_ex_stage. A behavioural model of the EX-stage
// contents is advanced every clock from the pipeline rules; a compare
// process checks every DUT output against it on each falling edge. Directed
// scenarios with literal expectations pin the model down, followed by a
// randomized phase and an asynchronous reset in mid-stream.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

`ifdef IDEX_FORWARD_EN
    localparam logic FWD_EXPECT = 1'b1;
`else
    localparam logic FWD_EXPECT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    logic [6:0]        id_op;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic [DATA_W-1:0] id_data1, id_data2, id_sdata;
    logic              mem_valid, mem_regwrite;
    logic [REG_AW-1:0] mem_rd;
    logic              ex_hold, flush;
    logic              id_stall, forw_on, ex_valid, ex_regwrite, ex_isload;
    logic [6:0]        ex_op;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [DATA_W-1:0] ex_data1, ex_data2, ex_sdata;
    logic [1:0]        forwA, forwB;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    typedef struct {
        logic              valid;
        logic              regwrite;
        logic              isload;
        logic [6:0]        op;
        logic [REG_AW-1:0] rs1, rs2, rd;
        logic [DATA_W-1:0] d1, d2, sd;
        logic [1:0]        fa, fb;
    } exState_t;

    exState_t model = '{default: 0};

    logic [6:0] opTable [10] = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'b1111111};

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_data1(id_data1), .id_data2(id_data2), .id_sdata(id_sdata),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .ex_hold(ex_hold), .flush(flush),
        .id_stall(id_stall), .forw_on(forw_on),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_isload(ex_isload),
        .ex_op(ex_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_sdata(ex_sdata),
        .forwA(forwA), .forwB(forwB)
    );

    // Instruction-class questions answered straight from the opcode
    function automatic bit readsRs1(logic [6:0] op);
        return !(op inside {OP_JAL, OP_LUI, OP_AUIPC});
    endfunction

    function automatic bit readsRs2(logic [6:0] op);
        return op inside {OP_R, OP_S, OP_B};
    endfunction

    function automatic bit writesRd(logic [6:0] op);
        return op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    endfunction

    // True when a producer (valid, writes, rd) feeds a used source register
    function automatic bit producerHits(bit v, bit w, logic [REG_AW-1:0] rd,
                                        logic [REG_AW-1:0] src, bit used);
        return used && v && w && (rd != 0) && (rd == src);
    endfunction

    function automatic logic [1:0] expectSel(logic [REG_AW-1:0] src, bit used);
        if (producerHits(model.valid, model.regwrite, model.rd, src, used)) return 2'b01;
        if (producerHits(mem_valid, mem_regwrite, mem_rd, src, used)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit expectHazard();
`ifdef IDEX_FORWARD_EN
        return id_valid && model.valid && model.isload && (model.rd != 0) &&
               ((readsRs1(id_op) && model.rd == id_rs1) ||
                (readsRs2(id_op) && model.rd == id_rs2));
`else
        return id_valid &&
               (producerHits(model.valid, model.regwrite, model.rd, id_rs1, readsRs1(id_op)) ||
                producerHits(model.valid, model.regwrite, model.rd, id_rs2, readsRs2(id_op)) ||
                producerHits(mem_valid, mem_regwrite, mem_rd, id_rs1, readsRs1(id_op)) ||
                producerHits(mem_valid, mem_regwrite, mem_rd, id_rs2, readsRs2(id_op)));
`endif
    endfunction

    function automatic bit expectStall();
        if (ex_hold) return 1'b1;
        if (flush) return 1'b0;
        return expectHazard();
    endfunction

    function automatic exState_t nextState();
        exState_t n;
        n = model;
        if (ex_hold) return n;
        n = '{default: 0};
        if (flush || expectHazard()) return n;
        n.valid    = id_valid;
        n.regwrite = id_valid && writesRd(id_op);
        n.isload   = id_valid && (id_op == OP_LOAD);
        n.op       = id_op;
        n.rs1      = id_rs1;
        n.rs2      = id_rs2;
        n.rd       = id_rd;
        n.d1       = id_data1;
        n.d2       = id_data2;
        n.sd       = id_sdata;
`ifdef IDEX_FORWARD_EN
        n.fa       = expectSel(id_rs1, readsRs1(id_op));
        n.fb       = expectSel(id_rs2, readsRs2(id_op));
`endif
        return n;
    endfunction

    // Reference model of the EX-stage contents
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model <= '{default: 0};
        else        model <= nextState();
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("ex_valid",    ex_valid,    model.valid);
            checkOutput("ex_regwrite", ex_regwrite, model.regwrite);
            checkOutput("ex_isload",   ex_isload,   model.isload);
            checkOutput("ex_op",       ex_op,       model.op);
            checkOutput("ex_rs1",      ex_rs1,      model.rs1);
            checkOutput("ex_rs2",      ex_rs2,      model.rs2);
            checkOutput("ex_rd",       ex_rd,       model.rd);
            checkOutput("ex_data1",    ex_data1,    model.d1);
            checkOutput("ex_data2",    ex_data2,    model.d2);
            checkOutput("ex_sdata",    ex_sdata,    model.sd);
            checkOutput("forwA",       forwA,       model.fa);
            checkOutput("forwB",       forwB,       model.fb);
            checkOutput("id_stall",    id_stall,    expectStall());
            checkOutput("forw_on",     forw_on,     FWD_EXPECT);
        end
    end

    task automatic setId(bit v, logic [6:0] op, logic [REG_AW-1:0] rs1,
                         logic [REG_AW-1:0] rs2, logic [REG_AW-1:0] rd);
        id_valid = v;
        id_op    = op;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_data1 = $urandom;
        id_data2 = $urandom;
        id_sdata = $urandom;
    endtask

    task automatic setMem(bit v, bit w, logic [REG_AW-1:0] rd);
        mem_valid    = v;
        mem_regwrite = w;
        mem_rd       = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(int cycles);
        for (int i = 0; i < cycles; i++) begin
            setId($urandom_range(0, 9) != 0, opTable[$urandom_range(0, 9)],
                  REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
                  REG_AW'($urandom_range(0, 3)));
            setMem($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                   REG_AW'($urandom_range(0, 3)));
            ex_hold = ($urandom_range(0, 9) == 0);
            flush   = ($urandom_range(0, 9) == 0);
            tick();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        ex_hold = 1'b0;
        flush   = 1'b0;
        setId(0, OP_R, 0, 0, 0);
        setMem(0, 0, 0);
        tick();
        tick();
        rst_n   = 1'b1;
        checkEn = 1'b1;
        checkOutput("reset ex_valid", ex_valid, 0);
        checkOutput("reset forwA",    forwA,    0);
        checkOutput("reset ex_data1", ex_data1, 0);

        // Producer add x5 in EX, then consumer add x6,x5,x7
        setId(1, OP_R, 1, 2, 5);
        tick();
        checkOutput("add x5 rd", ex_rd, 5);
        setId(1, OP_R, 5, 7, 6);
`ifdef IDEX_FORWARD_EN
        #1 checkOutput("ex-ex stall", id_stall, 0);
        tick();
        checkOutput("ex-ex rd",    ex_rd, 6);
        checkOutput("ex-ex forwA", forwA, 2'b01);
        checkOutput("ex-ex forwB", forwB, 2'b00);

        // MEM producer x7, then EX producer x7 taking priority
        setMem(1, 1, 7);
        setId(1, OP_R, 1, 7, 8);
        tick();
        checkOutput("mem forwB", forwB, 2'b10);
        setId(1, OP_R, 1, 2, 7);
        tick();
        setId(1, OP_R, 1, 7, 8);
        tick();
        checkOutput("priority forwB", forwB, 2'b01);

        // Load-use: lw x5 then add x6,x5,x1
        setMem(0, 0, 0);
        setId(1, OP_LOAD, 2, 0, 5);
        tick();
        setId(1, OP_R, 5, 1, 6);
        #1 checkOutput("lu stall", id_stall, 1);
        tick();
        checkOutput("lu bubble valid", ex_valid, 0);
        checkOutput("lu bubble rd",    ex_rd,    0);
        setMem(1, 1, 5);
        #1 checkOutput("lu release", id_stall, 0);
        tick();
        checkOutput("lu consumer rd",    ex_rd,    6);
        checkOutput("lu consumer forwA", forwA,    2'b10);
`else
        #1 checkOutput("raw ex stall", id_stall, 1);
        tick();
        checkOutput("raw ex bubble", ex_valid, 0);
        setMem(1, 1, 5);
        #1 checkOutput("raw mem stall", id_stall, 1);
        tick();
        checkOutput("raw mem bubble", ex_valid, 0);
        setMem(0, 0, 0);
        #1 checkOutput("raw release", id_stall, 0);
        tick();
        checkOutput("raw consumer rd",    ex_rd, 6);
        checkOutput("raw consumer forwA", forwA, 2'b00);
`endif

        // Flush beats a pending dependence
        setMem(0, 0, 0);
        setId(1, OP_LUI, 0, 0, 4);
        tick();
        flush = 1'b1;
        setId(1, OP_R, 4, 4, 9);
        #1 checkOutput("flush stall", id_stall, 0);
        tick();
        checkOutput("flush valid", ex_valid, 0);
        checkOutput("flush rd",    ex_rd,    0);
        flush = 1'b0;

        // Hold wins over flush and freezes the stage
        setId(1, OP_LUI, 0, 0, 4);
        tick();
        ex_hold = 1'b1;
        flush   = 1'b1;
        setId(1, OP_R, 1, 2, 9);
        #1 checkOutput("hold stall", id_stall, 1);
        tick();
        checkOutput("hold valid", ex_valid, 1);
        checkOutput("hold rd",    ex_rd,    4);
        checkOutput("hold op",    ex_op,    OP_LUI);
        ex_hold = 1'b0;
        flush   = 1'b0;

        // x0 producer never forwards or stalls
        setId(1, OP_R, 1, 2, 0);
        tick();
        setId(1, OP_R, 0, 0, 3);
        #1 checkOutput("x0 stall", id_stall, 0);
        tick();
        checkOutput("x0 forwA", forwA, 2'b00);
        checkOutput("x0 forwB", forwB, 2'b00);

        // Store data dependence sw x9,0(x2)
        setId(1, OP_R, 1, 2, 9);
        tick();
        setId(1, OP_S, 2, 9, 0);
`ifdef IDEX_FORWARD_EN
        tick();
        checkOutput("store forwB", forwB, 2'b01);
        checkOutput("store forwA", forwA, 2'b00);
`else
        #1 checkOutput("store stall", id_stall, 1);
        tick();
`endif

        applyStimulus(3000);

        // Asynchronous reset in mid-stream
        ex_hold = 1'b0;
        flush   = 1'b0;
        setMem(0, 0, 0);
        setId(1, OP_R, 1, 2, 3);
        tick();
        checkOutput("pre-reset valid", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset valid",    ex_valid,    0);
        checkOutput("async reset rd",       ex_rd,       0);
        checkOutput("async reset regwrite", ex_regwrite, 0);
        tick();
        rst_n = 1'b1;
        setId(1, OP_R, 1, 2, 3);
        tick();
        checkOutput("recovery valid", ex_valid, 1);
        checkOutput("recovery rd",    ex_rd,    3);

        applyStimulus(500);
        @(negedge clk);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
